regfile_sb: RTL and testbench
=============================

// Module: regfile_sb
// PURPOSE
//   Parametrised integer register file for the next SaRV core generation: NRP read ports,
//   one sized write port (byte/half/word, zero- or sign-extended), write-to-read bypass,
//   per-register busy scoreboard for in-flight loads, and a sequenced clear after reset.
//   Sits between decode (read ports) and writeback (write port); x0 is hardwired to zero.
// PARAMETERS
//   XLEN   32  data width; 32 or 64 only
//   NREGS  32  number of architectural registers; power of two, 2..32
//   AW     5   address width; must equal log2(NREGS)
//   NRP    2   number of read ports, 1..4
// PORTS
//   clk         in   1         clock; all state updates on posedge
//   rst         in   1         synchronous active-high reset
//   init_done   out  1         1 = clear sequence finished, file usable
//   rd_addr_i   in   NRP*AW    read addresses; port p at [p*AW +: AW]
//   rd_data_c   out  NRP*XLEN  combinational read data, bypassed
//   rd_data_o   out  NRP*XLEN  rd_data_c registered at posedge
//   rd_busy_o   out  NRP       combinational: addressed register has a pending load
//   wr_addr_i   in   AW        write address
//   wr_data_i   in   XLEN      write data
//   wr_size_i   in   2         00 none, 01 byte, 10 half, 11 full XLEN
//   wr_sext_i   in   1         1 = sign-extend byte/half, 0 = zero-extend
//   busy_set_i  in   1         mark busy_addr_i pending (load issued)
//   busy_addr_i in   AW        register to mark busy
// BEHAVIOUR
//   Reset/clear FSM, states CLEAR and READY:
//   - rst=1 at posedge: state<=CLEAR, cnt<=0, all busy bits<=0, rd_data_o<=0, init_done<=0.
//   - CLEAR: each posedge regs[cnt]<=0, cnt<=cnt+1; after writing NREGS-1 -> READY,
//     init_done<=1 (init_done rises NREGS cycles after rst deasserts).
//   - In CLEAR: writes and busy_set_i ignored; rd_data_c=0, rd_busy_o=0 on all ports.
//   - rst during CLEAR or READY restarts the sequence at cnt=0; contents not preserved.
//   Write (READY only): effective when wr_size_i!=00 and wr_addr_i!=0; updates on posedge.
//   - ext value: 01 -> wr_data_i[7:0], 10 -> [15:0], 11 -> all XLEN bits;
//     byte/half filled to XLEN with bit 7/15 if wr_sext_i else zeros.
//   - Write to address 0 or with size 00: no state change.
//   Read port p (READY): addr 0 -> 0; else if effective write to same addr this cycle ->
//     ext value (bypass); else regs[addr]. rd_data_o[p] <= rd_data_c[p] each posedge.
//   Scoreboard: busy[0] constant 0.
//   - Effective write clears busy[wr_addr_i] at posedge.
//   - busy_set_i sets busy[busy_addr_i] at posedge (addr 0 ignored).
//   - Set and write to same addr in one cycle: set wins (busy stays 1).
//   - rd_busy_o[p] = busy[addr]; forced 0 when an effective write to addr is in the same
//     cycle and busy_set_i does not target addr (data is being bypassed).
//   - Multiple read ports on same addr return identical data/busy.
//   Latency: rd_data_c 0 cycles, rd_data_o 1 cycle, write visible to regs next cycle.
// TESTING
//   1 rst for 1 cycle, NREGS=32 -> init_done=0 for 32 cycles then 1; every reg reads 0.
//   2 write x5 data 0x0000_0080 size 01 sext=1 -> x5 reads 0xFFFF_FF80; sext=0 -> 0x0000_0080;
//     size 10 data 0x1234_8001 sext=1 -> 0xFFFF_8001.
//   3 same-cycle write x7=0xDEADBEEF and read x7 on both ports -> rd_data_c=0xDEADBEEF both
//     ports that cycle, rd_data_o=0xDEADBEEF next cycle; write x0=0x1 -> x0 reads 0.
//   4 busy_set x9, then read x9 -> rd_busy_o=1; write x9 -> rd_busy_o=0 that cycle, busy
//     clear after; simultaneous busy_set x9 and write x9 -> busy remains 1.
//   5 rst asserted at cnt=10 of CLEAR -> cnt restarts, init_done rises 32 cycles after rst
//     drops; writes/busy_set attempted during CLEAR leave all regs 0, busy 0.
//   6 XLEN=64, NRP=4: write size 11 0x8000_0000_0000_0001 -> all four ports read it exactly.

Source files
------------

// File: rtl/regfile_sb_if.sv
// Register-file bus: read ports, sized write port and load-scoreboard set port.
interface regfile_sb_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5,
  parameter int NRP  = 2
);
  logic [NRP*AW-1:0]   rd_addr_i;
  logic [NRP*XLEN-1:0] rd_data_c;
  logic [NRP*XLEN-1:0] rd_data_o;
  logic [NRP-1:0]      rd_busy_o;
  logic [AW-1:0]       wr_addr_i;
  logic [XLEN-1:0]     wr_data_i;
  logic [1:0]          wr_size_i;
  logic                wr_sext_i;
  logic                busy_set_i;
  logic [AW-1:0]       busy_addr_i;

  modport master (
    output rd_addr_i, wr_addr_i, wr_data_i, wr_size_i, wr_sext_i, busy_set_i, busy_addr_i,
    input  rd_data_c, rd_data_o, rd_busy_o
  );

  modport slave (
    input  rd_addr_i, wr_addr_i, wr_data_i, wr_size_i, wr_sext_i, busy_set_i, busy_addr_i,
    output rd_data_c, rd_data_o, rd_busy_o
  );
endinterface

// File: rtl/regfile_sb.sv
// Integer register file with write-to-read bypass, sized/extended writes,
// load busy scoreboard and a one-register-per-cycle clear after reset.
module regfile_sb #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int AW    = 5,
  parameter int NRP   = 2
) (
  input  logic         clk,
  input  logic         rst,
  output logic         init_done,
  regfile_sb_if.slave  bus
);
  typedef enum logic {CLEAR, READY} state_e;

  state_e              state_q, state_d;
  logic [AW-1:0]       cnt_q, cnt_d;
  logic                init_done_q, init_done_d;
  logic [NREGS-1:0]    busy_q, busy_d;
  logic [XLEN-1:0]     regs_q [NREGS];
  logic [XLEN-1:0]     regs_d [NREGS];
  logic [NRP*XLEN-1:0] rd_data_o_q, rd_data_o_d;
  logic [XLEN-1:0]     ext_val;
  logic                ready;
  logic                wr_eff;
  logic                set_eff;

  assign ready   = (state_q == READY);
  assign wr_eff  = ready && (bus.wr_size_i != 2'b00) && (bus.wr_addr_i != '0);
  assign set_eff = ready && bus.busy_set_i && (bus.busy_addr_i != '0);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_done_d = init_done_q;
    case (state_q)
      CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == AW'(NREGS - 1)) begin
          state_d     = READY;
          init_done_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    ext_val = '0;
    case (bus.wr_size_i)
      2'b01:   ext_val = {{(XLEN-8){bus.wr_sext_i & bus.wr_data_i[7]}}, bus.wr_data_i[7:0]};
      2'b10:   ext_val = {{(XLEN-16){bus.wr_sext_i & bus.wr_data_i[15]}}, bus.wr_data_i[15:0]};
      2'b11:   ext_val = bus.wr_data_i;
      default: ext_val = '0;
    endcase
  end

  always_comb begin
    for (int unsigned i = 0; i < NREGS; i++) regs_d[i] = regs_q[i];
    if (!ready)      regs_d[cnt_q] = '0;
    else if (wr_eff) regs_d[bus.wr_addr_i] = ext_val;
  end

  // Set is applied after the write-clear so a same-cycle set on the written register wins.
  always_comb begin
    busy_d = busy_q;
    if (wr_eff)  busy_d[bus.wr_addr_i]   = 1'b0;
    if (set_eff) busy_d[bus.busy_addr_i] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_comb begin
    bus.rd_data_c = '0;
    bus.rd_busy_o = '0;
    for (int unsigned p = 0; p < NRP; p++) begin
      if (ready && (bus.rd_addr_i[p*AW +: AW] != '0)) begin
        if (wr_eff && (bus.wr_addr_i == bus.rd_addr_i[p*AW +: AW])) begin
          bus.rd_data_c[p*XLEN +: XLEN] = ext_val;
          bus.rd_busy_o[p] = busy_q[bus.rd_addr_i[p*AW +: AW]] && bus.busy_set_i &&
                             (bus.busy_addr_i == bus.rd_addr_i[p*AW +: AW]);
        end else begin
          bus.rd_data_c[p*XLEN +: XLEN] = regs_q[bus.rd_addr_i[p*AW +: AW]];
          bus.rd_busy_o[p] = busy_q[bus.rd_addr_i[p*AW +: AW]];
        end
      end
    end
  end

  assign rd_data_o_d   = bus.rd_data_c;
  assign bus.rd_data_o = rd_data_o_q;
  assign init_done     = init_done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= CLEAR;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
      busy_q      <= '0;
      rd_data_o_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= init_done_d;
      busy_q      <= busy_d;
      rd_data_o_q <= rd_data_o_d;
    end
  end

  // Contents need no reset: the clear sequence zeroes every register before READY.
  always_ff @(posedge clk) begin
    regs_q <= regs_d;
  end
endmodule

// File: tb/tb_regfile_sb.sv
// Directed checks of regfile_sb: clear sequence, sized writes, bypass, scoreboard, 64-bit/4-port build.
module tb_regfile_sb;
  logic clk = 1'b0;
  logic rst;
  logic init_done32, init_done64;
  int   n_total = 0;
  int   n_pass  = 0;

  always #5 clk = ~clk;

  regfile_sb_if #(.XLEN(32), .AW(5), .NRP(2)) b32 ();
  regfile_sb_if #(.XLEN(64), .AW(5), .NRP(4)) b64 ();

  regfile_sb #(.XLEN(32), .NREGS(32), .AW(5), .NRP(2)) u32 (
    .clk(clk), .rst(rst), .init_done(init_done32), .bus(b32.slave));
  regfile_sb #(.XLEN(64), .NREGS(32), .AW(5), .NRP(4)) u64 (
    .clk(clk), .rst(rst), .init_done(init_done64), .bus(b64.slave));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr32(input logic [4:0] a, input logic [31:0] d, input logic [1:0] sz, input logic sx);
    b32.wr_addr_i = a; b32.wr_data_i = d; b32.wr_size_i = sz; b32.wr_sext_i = sx;
  endtask

  initial begin
    rst = 1'b1;
    b32.rd_addr_i = '0; b32.busy_set_i = 1'b0; b32.busy_addr_i = '0;
    wr32(5'd0, 32'h0, 2'b00, 1'b0);
    b64.rd_addr_i = '0; b64.wr_addr_i = '0; b64.wr_data_i = '0; b64.wr_size_i = 2'b00;
    b64.wr_sext_i = 1'b0; b64.busy_set_i = 1'b0; b64.busy_addr_i = '0;
    tick();
    chk("rst_init_done", init_done32, 1'b0);
    chk("rst_rd_data_o", b32.rd_data_o, '0);
    rst = 1'b0;

    // clear sequence: init_done stays low 31 edges, rises on the 32nd
    for (int i = 1; i <= 32; i++) begin
      tick();
      chk($sformatf("clr_init_done_%0d", i), init_done32, (i == 32));
    end
    for (int a = 0; a < 32; a++) begin
      b32.rd_addr_i = {5'(31 - a), 5'(a)};
      #1;
      chk($sformatf("zero_x%0d", a), b32.rd_data_c, '0);
    end

    // sized writes to x5
    b32.rd_addr_i = {5'd5, 5'd5};
    wr32(5'd5, 32'h0000_0080, 2'b01, 1'b1);
    #1 chk("byte_sext_bypass", b32.rd_data_c[31:0], 32'hFFFF_FF80);
    tick(); b32.wr_size_i = 2'b00;
    #1 chk("byte_sext_reg", b32.rd_data_c[31:0], 32'hFFFF_FF80);
    wr32(5'd5, 32'h0000_0080, 2'b01, 1'b0);
    tick(); b32.wr_size_i = 2'b00;
    #1 chk("byte_zext_reg", b32.rd_data_c[31:0], 32'h0000_0080);
    wr32(5'd5, 32'h1234_8001, 2'b10, 1'b1);
    tick(); b32.wr_size_i = 2'b00;
    #1 chk("half_sext_reg", b32.rd_data_c[63:32], 32'hFFFF_8001);

    // bypass on both ports, registered output, x0 hardwired
    b32.rd_addr_i = {5'd7, 5'd7};
    wr32(5'd7, 32'hDEAD_BEEF, 2'b11, 1'b0);
    #1 chk("bypass_c", b32.rd_data_c, {32'hDEAD_BEEF, 32'hDEAD_BEEF});
    tick(); b32.wr_size_i = 2'b00;
    chk("bypass_o", b32.rd_data_o, {32'hDEAD_BEEF, 32'hDEAD_BEEF});
    b32.rd_addr_i = {5'd0, 5'd0};
    wr32(5'd0, 32'h1, 2'b11, 1'b0);
    #1 chk("x0_write_c", b32.rd_data_c, '0);
    tick(); b32.wr_size_i = 2'b00;
    #1 chk("x0_after", b32.rd_data_c, '0);

    // scoreboard
    b32.busy_set_i = 1'b1; b32.busy_addr_i = 5'd9;
    tick(); b32.busy_set_i = 1'b0;
    b32.rd_addr_i = {5'd0, 5'd9};
    #1 chk("busy_set", b32.rd_busy_o, 2'b01);
    wr32(5'd9, 32'h55, 2'b11, 1'b0);
    #1 chk("busy_fwd_clear", b32.rd_busy_o, 2'b00);
    tick(); b32.wr_size_i = 2'b00;
    #1 chk("busy_cleared", b32.rd_busy_o, 2'b00);
    chk("busy_data", b32.rd_data_c[31:0], 32'h55);
    wr32(5'd9, 32'h66, 2'b11, 1'b0);
    b32.busy_set_i = 1'b1; b32.busy_addr_i = 5'd9;
    tick(); b32.wr_size_i = 2'b00; b32.busy_set_i = 1'b0;
    #1 chk("set_wins", b32.rd_busy_o, 2'b01);
    chk("set_wins_data", b32.rd_data_c[31:0], 32'h66);
    b32.rd_addr_i = {5'd3, 5'd9};
    wr32(5'd9, 32'h77, 2'b11, 1'b0);
    b32.busy_set_i = 1'b1; b32.busy_addr_i = 5'd3;
    #1 chk("busy_fwd_other_set", b32.rd_busy_o, 2'b00);
    tick(); b32.wr_size_i = 2'b00; b32.busy_set_i = 1'b0;
    #1 chk("busy_x3_x9", b32.rd_busy_o, 2'b10);
    b32.busy_set_i = 1'b1; b32.busy_addr_i = 5'd0;
    tick(); b32.busy_set_i = 1'b0;
    b32.rd_addr_i = {5'd0, 5'd0};
    #1 chk("busy_x0", b32.rd_busy_o, 2'b00);

    // 64-bit, four ports
    b64.rd_addr_i = {5'd12, 5'd12, 5'd12, 5'd12};
    b64.wr_addr_i = 5'd12; b64.wr_data_i = 64'h8000_0000_0000_0001; b64.wr_size_i = 2'b11;
    #1 chk("x64_bypass", b64.rd_data_c, {4{64'h8000_0000_0000_0001}});
    tick(); b64.wr_size_i = 2'b00;
    #1 chk("x64_reg", b64.rd_data_c, {4{64'h8000_0000_0000_0001}});
    chk("x64_o", b64.rd_data_o, {4{64'h8000_0000_0000_0001}});
    b64.wr_addr_i = 5'd13; b64.wr_data_i = 64'h80; b64.wr_size_i = 2'b01; b64.wr_sext_i = 1'b1;
    b64.rd_addr_i = {5'd0, 5'd12, 5'd13, 5'd13};
    #1 chk("x64_byte_sext", b64.rd_data_c[63:0], 64'hFFFF_FFFF_FFFF_FF80);
    chk("x64_port3_x0", b64.rd_data_c[255:192], '0);
    tick(); b64.wr_size_i = 2'b00;

    // reset mid-clear restarts; writes/sets during clear are ignored
    rst = 1'b1;
    tick(); rst = 1'b0;
    for (int i = 1; i <= 10; i++) tick();
    chk("clr_mid_init_done", init_done32, 1'b0);
    rst = 1'b1;
    tick(); rst = 1'b0;
    b32.rd_addr_i = {5'd7, 5'd5};
    wr32(5'd5, 32'hFFFF_FFFF, 2'b11, 1'b1);
    b32.busy_set_i = 1'b1; b32.busy_addr_i = 5'd5;
    #1 chk("clear_rd_c", b32.rd_data_c, '0);
    chk("clear_rd_busy", b32.rd_busy_o, 2'b00);
    for (int i = 1; i <= 32; i++) begin
      if (i == 21) begin b32.wr_size_i = 2'b00; b32.busy_set_i = 1'b0; end
      tick();
      if (i >= 31) chk($sformatf("restart_init_done_%0d", i), init_done32, (i == 32));
    end
    b32.rd_addr_i = {5'd9, 5'd5};
    #1 chk("restart_regs", b32.rd_data_c, '0);
    chk("restart_busy", b32.rd_busy_o, 2'b00);
    b32.rd_addr_i = {5'd3, 5'd7};
    #1 chk("restart_regs2", b32.rd_data_c, '0);
    chk("restart_busy2", b32.rd_busy_o, 2'b00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
